// File: rtl/conv_pkg.sv
// Shared definitions for the M_LEN x M_LEN sliding-window convolver.
//   acc_len()     : accumulator width that cannot overflow for M_LEN^2 products
//   offset_zero() : value of zero in offset-binary for a given output width
//   KERNEL_MODE / IMAGE_MODE : encodings of i_selecK_I
package conv_pkg;

   localparam logic KERNEL_MODE = 1'b0;
   localparam logic IMAGE_MODE  = 1'b1;

   function automatic int acc_len(input int bit_len, input int m_len);
      return 2*bit_len + $clog2(m_len*m_len);
   endfunction

   // Offset-binary zero is just the MSB set; callers truncate to their width.
   function automatic logic [63:0] offset_zero(input int out_len);
      return 64'd1 << (out_len-1);
   endfunction

endpackage

// File: rtl/conv_out_fmt.sv
// Output formatter: round half up, arithmetic shift, clip, offset binary.
// Purely combinational; the parent registers the results.
//   i_acc  : signed accumulator (ACC_LEN)
//   o_data : formatted result, MSB-inverted two's complement (OUT_LEN)
//   o_sat  : result was clipped to the OUT_LEN signed range
module conv_out_fmt #(
   parameter int ACC_LEN   = 20,
   parameter int OUT_LEN   = 13,
   parameter int OUT_SHIFT = 6
) (
   input  logic signed [ACC_LEN-1:0] i_acc,
   output logic        [OUT_LEN-1:0] o_data,
   output logic                      o_sat
);

   // One extra bit so adding the rounding constant can never wrap.
   localparam int RW = ACC_LEN + 1;
   localparam logic signed [RW-1:0] MAX_V = RW'((64'sd1 <<< (OUT_LEN-1)) - 64'sd1);
   localparam logic signed [RW-1:0] MIN_V = ~MAX_V;

   logic signed [RW-1:0]      acc_x;
   logic signed [RW-1:0]      r;
   logic        [OUT_LEN-1:0] r_clip;

   assign acc_x = {i_acc[ACC_LEN-1], i_acc};

   generate
      if (OUT_SHIFT > 0) begin : g_rnd
         localparam logic signed [RW-1:0] HALF = RW'(64'sd1 <<< (OUT_SHIFT-1));
         logic signed [RW-1:0] acc_rnd;
         assign acc_rnd = acc_x + HALF;
         assign r       = acc_rnd >>> OUT_SHIFT;
      end else begin : g_nornd
         assign r = acc_x;
      end
   endgenerate

   always_comb begin
      r_clip = r[OUT_LEN-1:0];
      o_sat  = 1'b0;
      if (r > MAX_V) begin
         r_clip = MAX_V[OUT_LEN-1:0];
         o_sat  = 1'b1;
      end else if (r < MIN_V) begin
         r_clip = MIN_V[OUT_LEN-1:0];
         o_sat  = 1'b1;
      end
   end

   assign o_data = {~r_clip[OUT_LEN-1], r_clip[OUT_LEN-2:0]};

endmodule

// File: rtl/conv_mxm_pipe.sv
// Parametrised M_LEN x M_LEN signed sliding-window convolver.
// Kernel and image window are column shift registers fed one column per beat;
// a 3-stage registered MAC (products, sum, format) produces one result per
// image beat once M_LEN image columns have arrived since reset/kernel load.
//   CLK100MHZ  : clock, rising edge
//   i_reset    : synchronous active-high reset
//   i_valid    : column beat qualifier
//   i_selecK_I : 0 = kernel column, 1 = image column
//   i_column   : M_LEN pixels, row r at [(r+1)*BIT_LEN-1 -: BIT_LEN]
//   o_data     : offset-binary result, held while o_valid = 0
//   o_valid    : one-cycle result strobe
//   o_sat      : result clipped (only with o_valid)
module conv_mxm_pipe
   import conv_pkg::*;
#(
   parameter int BIT_LEN   = 8,
   parameter int M_LEN     = 3,
   parameter int OUT_LEN   = 13,
   parameter int OUT_SHIFT = 6
) (
   input  logic                     CLK100MHZ,
   input  logic                     i_reset,
   input  logic                     i_valid,
   input  logic                     i_selecK_I,
   input  logic [M_LEN*BIT_LEN-1:0] i_column,
   output logic [OUT_LEN-1:0]       o_data,
   output logic                     o_valid,
   output logic                     o_sat
);

   localparam int ACC_LEN = acc_len(BIT_LEN, M_LEN);
   localparam int NPROD   = M_LEN*M_LEN;
   localparam int CW      = $clog2(M_LEN+1);
   localparam int STAGES  = 3;
   localparam int CTR     = M_LEN/2;
   localparam logic [OUT_LEN-1:0] OFFSET_ZERO = OUT_LEN'(offset_zero(OUT_LEN));
   localparam logic [BIT_LEN-1:0] UNITY       = BIT_LEN'(1 << OUT_SHIFT);
   localparam logic [CW-1:0]      FULL        = CW'(M_LEN);

   logic [M_LEN-1:0][M_LEN*BIT_LEN-1:0] win_q, win_d, ker_q, ker_d;
   logic [CW-1:0]                       cnt_q, cnt_d;
   logic [STAGES:0]                     vld_pipe_q, vld_pipe_d;
   logic signed [2*BIT_LEN-1:0]         prod_q [NPROD];
   logic signed [2*BIT_LEN-1:0]         prod_d [NPROD];
   logic signed [ACC_LEN-1:0]           acc_q, acc_d;
   logic [OUT_LEN-1:0]                  o_data_q, o_data_d, fmt_data;
   logic                                o_sat_q, o_sat_d, fmt_sat;
   logic                                kbeat, ibeat;

   // Column shift, fill tracking and stage-0 valid. vld_pipe[0] marks the
   // accepting edge; [1] products, [2] sum, [3] formatted output.
   always_comb begin
      kbeat = i_valid && (i_selecK_I == KERNEL_MODE);
      ibeat = i_valid && (i_selecK_I == IMAGE_MODE);
      win_d = win_q;
      ker_d = ker_q;
      cnt_d = cnt_q;
      if (kbeat) begin
         ker_d = {i_column, ker_q[M_LEN-1:1]};
         cnt_d = '0;   // results after a kernel change see only new image columns
      end
      if (ibeat) begin
         win_d = {i_column, win_q[M_LEN-1:1]};
         cnt_d = (cnt_q == FULL) ? cnt_q : cnt_q + 1'b1;
      end
      vld_pipe_d = {vld_pipe_q[STAGES-1:0], ibeat && (cnt_d == FULL)};
   end

   // S1 products read the registered window/kernel, so a kernel beat right
   // behind an image beat cannot disturb the result already accepted.
   always_comb begin
      for (int c = 0; c < M_LEN; c++) begin
         for (int r = 0; r < M_LEN; r++) begin
            prod_d[c*M_LEN+r] = $signed(win_q[c][r*BIT_LEN +: BIT_LEN]) *
                                $signed(ker_q[c][r*BIT_LEN +: BIT_LEN]);
         end
      end
   end

   always_comb begin
      acc_d = '0;
      for (int i = 0; i < NPROD; i++) acc_d = acc_d + ACC_LEN'(prod_q[i]);
   end

   conv_out_fmt #(
      .ACC_LEN  (ACC_LEN),
      .OUT_LEN  (OUT_LEN),
      .OUT_SHIFT(OUT_SHIFT)
   ) u_fmt (
      .i_acc (acc_q),
      .o_data(fmt_data),
      .o_sat (fmt_sat)
   );

   always_comb begin
      o_data_d = vld_pipe_q[2] ? fmt_data : o_data_q;
      o_sat_d  = vld_pipe_q[2] & fmt_sat;
   end

   always_ff @(posedge CLK100MHZ) begin
      if (i_reset) begin
         win_q                            <= '0;
         ker_q                            <= '0;
         ker_q[CTR][CTR*BIT_LEN +: BIT_LEN] <= UNITY;   // identity kernel
         cnt_q                            <= '0;
         vld_pipe_q                       <= '0;
         o_data_q                         <= OFFSET_ZERO;
         o_sat_q                          <= 1'b0;
      end else begin
         win_q      <= win_d;
         ker_q      <= ker_d;
         cnt_q      <= cnt_d;
         vld_pipe_q <= vld_pipe_d;
         o_data_q   <= o_data_d;
         o_sat_q    <= o_sat_d;
      end
   end

   // Datapath registers are qualified by vld_pipe, so they need no reset.
   always_ff @(posedge CLK100MHZ) begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
   end

   assign o_data  = o_data_q;
   assign o_sat   = o_sat_q;
   assign o_valid = vld_pipe_q[STAGES];

endmodule

// File: tb/tb_conv_mxm_pipe.sv
module tb_conv_mxm_pipe;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_valid = 1'b0;
   logic        i_selecK_I = 1'b0;
   logic [23:0] i_column = '0;
   logic [12:0] o_data;
   logic        o_valid, o_sat;
   logic [9:0]  s_data;
   logic        s_valid, s_sat;

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   conv_mxm_pipe #(.BIT_LEN(8), .M_LEN(3), .OUT_LEN(13), .OUT_SHIFT(6)) dut (
      .CLK100MHZ(clk), .i_reset(i_reset), .i_valid(i_valid), .i_selecK_I(i_selecK_I),
      .i_column(i_column), .o_data(o_data), .o_valid(o_valid), .o_sat(o_sat));

   conv_mxm_pipe #(.BIT_LEN(8), .M_LEN(3), .OUT_LEN(10), .OUT_SHIFT(6)) dut_s (
      .CLK100MHZ(clk), .i_reset(i_reset), .i_valid(i_valid), .i_selecK_I(i_selecK_I),
      .i_column(i_column), .o_data(s_data), .o_valid(s_valid), .o_sat(s_sat));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
   task automatic step(input logic v, input logic s, input logic [23:0] c);
      i_valid = v; i_selecK_I = s; i_column = c;
      @(posedge clk); #1;
   endtask

   function automatic logic [23:0] col3(input int r0, input int r1, input int r2);
      return {8'(r2), 8'(r1), 8'(r0)};
   endfunction

   // Called right after the accepting image beat: result appears 3 edges later.
   task automatic expect_result(input string tag, input logic [12:0] d, input logic s);
      step(0, 0, '0); chk({tag, "_lat1"}, o_valid, 0);
      step(0, 0, '0); chk({tag, "_lat2"}, o_valid, 0);
      step(0, 0, '0); chk({tag, "_vld"}, o_valid, 1);
      chk({tag, "_data"}, o_data, d);
      chk({tag, "_sat"}, o_sat, s);
   endtask

   initial begin
      int nA, nB, firstB;

      // reset
      step(0, 0, '0); step(0, 0, '0);
      i_reset = 1'b0;
      chk("rst_data", o_data, 13'h1000);
      chk("rst_valid", o_valid, 0);
      chk("rst_sat", o_sat, 0);
      chk("rst_data_s", s_data, 10'h200);

      // identity kernel after reset
      step(1, 1, col3(1, 2, 3)); chk("id_b1", o_valid, 0);
      step(1, 1, col3(4, 5, 6)); chk("id_b2", o_valid, 0);
      step(1, 1, col3(7, 8, 9)); chk("id_b3", o_valid, 0);
      expect_result("id", 13'h1005, 0);
      step(0, 0, '0);
      chk("id_pulse", o_valid, 0);
      chk("id_hold", o_data, 13'h1005);

      // unity kernel everywhere, flat image of 10
      for (int i = 0; i < 3; i++) begin
         step(1, 0, col3(8'h40, 8'h40, 8'h40)); chk("kl_kbeat", o_valid, 0);
      end
      step(1, 1, col3(10, 10, 10)); chk("kl_b1", o_valid, 0);
      step(1, 1, col3(10, 10, 10)); chk("kl_b2", o_valid, 0);
      step(1, 1, col3(10, 10, 10));
      expect_result("kl", 13'h105A, 0);

      // saturation: 145161 -> 2268 fits 13 bits, clips at 10 bits
      for (int i = 0; i < 3; i++) step(1, 0, col3(8'h7F, 8'h7F, 8'h7F));
      for (int i = 0; i < 3; i++) step(1, 1, col3(8'h7F, 8'h7F, 8'h7F));
      step(0, 0, '0); step(0, 0, '0); step(0, 0, '0);
      chk("sat_vld_s", s_valid, 1);
      chk("sat_data_s", s_data, 10'h3FF);
      chk("sat_sat_s", s_sat, 1);
      chk("sat_data13", o_data, 13'h18DC);
      chk("sat_sat13", o_sat, 0);

      // negative rounding with identity kernel
      step(1, 0, col3(0, 0, 0));
      step(1, 0, col3(0, 8'h40, 0));
      step(1, 0, col3(0, 0, 0));
      step(1, 1, col3(0, 0, 0));
      step(1, 1, col3(0, 8'hFF, 0));
      step(1, 1, col3(0, 0, 0));
      expect_result("neg1", 13'h0FFF, 0);
      step(1, 1, col3(0, 8'h80, 0));
      expect_result("zero", 13'h1000, 0);
      step(1, 1, col3(0, 0, 0));
      expect_result("neg128", 13'h0F80, 0);

      // gapped streaming, then a kernel beat mid-stream
      nA = 0;
      for (int i = 0; i < 6; i++) begin
         step(1, 1, col3(i+1, i+1, i+1)); nA += int'(o_valid);
         step(0, 0, '0);                  nA += int'(o_valid);
      end
      chk("gap_cnt", nA, 5);
      nB = 0; firstB = -1;
      step(1, 0, col3(0, 8'h40, 0));
      nB += int'(o_valid);
      for (int k = 1; k <= 14; k++) begin
         if (k <= 10 && (k % 2) == 1) step(1, 1, col3(k, k, k));
         else                         step(0, 0, '0);
         if (o_valid) begin
            nB++;
            if (k > 1 && firstB < 0) firstB = k;
         end
      end
      chk("kint_cnt", nB, 4);
      chk("kint_first", firstB, 8);

      // reset with two results in flight
      step(1, 1, col3(3, 3, 3));
      step(1, 1, col3(4, 4, 4));
      i_reset = 1'b1;
      step(0, 0, '0);
      i_reset = 1'b0;
      chk("mrst_valid", o_valid, 0);
      chk("mrst_data", o_data, 13'h1000);
      chk("mrst_sat", o_sat, 0);
      nA = 0;
      for (int i = 0; i < 4; i++) begin
         step(0, 0, '0); nA += int'(o_valid);
      end
      chk("mrst_drop", nA, 0);
      step(1, 1, col3(1, 2, 3));
      step(1, 1, col3(4, 5, 6)); chk("mrst_b2", o_valid, 0);
      step(1, 1, col3(7, 8, 9));
      expect_result("mrst_id", 13'h1005, 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
